// File: rtl/instruction_seq_ram.sv
// Instruction store between the UART byte receiver and the decoder: captures a
// delimiter-separated byte stream in WRITE, replays it in READ, single-steps it in DEBUG.
module instruction_seq_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter     DELIM      = 8'h24,
    parameter     IDLE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            MODE,
    input  logic                  DEBUG,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic                  done
);

    localparam logic [1:0] M_READ  = 2'd0;
    localparam logic [1:0] M_WRITE = 2'd1;
    localparam logic [1:0] M_DEBUG = 2'd2;
    localparam logic [1:0] M_HOLD  = 2'd3;

    localparam logic [DATA_WIDTH-1:0] DELIM_C = DATA_WIDTH'(DELIM);
    localparam logic [DATA_WIDTH-1:0] IDLE_C  = DATA_WIDTH'(IDLE);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {ARMED, WAIT_DELIM} cap_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]      mode_q;
    logic            debug_q;
    cap_state_t      state_q, state_d;
    logic            mode_entry, capture_en, cap_store, cap_drop;
    logic            step_req, can_step;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign mode_entry = (MODE != mode_q);
    assign capture_en = !rst && (MODE == M_WRITE) && !mode_entry;
    assign rd_addr    = pc + PC_ONE;
    // Compare in count width so an empty program never underflows count-1.
    assign can_step   = ({1'b0, pc} + CNT_ONE) < count;
    assign step_req   = !mode_entry &&
                        ((MODE == M_READ) || ((MODE == M_DEBUG) && DEBUG && !debug_q));

    assign full = (count == DEPTH_C);
    assign done = (count == '0) || ({1'b0, pc} == (count - CNT_ONE));

    always_comb begin
        state_d   = state_q;
        cap_store = 1'b0;
        cap_drop  = 1'b0;
        if (!rst && mode_entry && (MODE == M_WRITE)) begin
            state_d = ARMED;
        end else if (capture_en) begin
            case (state_q)
                ARMED: begin
                    if ((data_in != IDLE_C) && (data_in != DELIM_C)) begin
                        state_d = WAIT_DELIM;
                        if (count < DEPTH_C) cap_store = 1'b1;
                        else                 cap_drop  = 1'b1;
                    end
                end
                WAIT_DELIM: begin
                    if (data_in == DELIM_C) state_d = ARMED;
                end
                default: state_d = ARMED;
            endcase
        end
    end

    // Storage is never reset; count bounds what is reachable.
    always_ff @(posedge clk) begin
        if (cap_store) mem[count[ADDR_WIDTH-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= M_HOLD;
            debug_q  <= 1'b0;
            state_q  <= ARMED;
            data_out <= '0;
            pc       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            mode_q  <= MODE;
            debug_q <= DEBUG;
            state_q <= state_d;
            if (mode_entry) begin
                if (MODE == M_WRITE) begin
                    count    <= '0;
                    overflow <= 1'b0;
                end else if ((MODE == M_READ) || (MODE == M_DEBUG)) begin
                    pc       <= '0;
                    data_out <= (count != '0) ? mem[0] : '0;
                end
            end else begin
                if (cap_store) count    <= count + CNT_ONE;
                if (cap_drop)  overflow <= 1'b1;
                if (step_req && can_step) begin
                    pc       <= rd_addr;
                    data_out <= mem[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_seq_ram.sv
// Scoreboard bench for instruction_seq_ram: a default-depth instance and a DEPTH=4
// instance share the same stimulus; data_out expectations are queued per clock.
module tb_instruction_seq_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] MODE;
    logic       DEBUG;
    logic [7:0] data_in;

    logic [7:0] data_out, data_out_s;
    logic [7:0] pc;
    logic [1:0] pc_s;
    logic [8:0] count;
    logic [2:0] count_s;
    logic       full, overflow, done;
    logic       full_s, overflow_s, done_s;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb   [$];
    logic [31:0] sb_s [$];

    always #5 clk = ~clk;

    instruction_seq_ram u_dut (
        .clk(clk), .rst(rst), .MODE(MODE), .DEBUG(DEBUG), .data_in(data_in),
        .data_out(data_out), .pc(pc), .count(count), .full(full),
        .overflow(overflow), .done(done)
    );

    instruction_seq_ram #(.DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .MODE(MODE), .DEBUG(DEBUG), .data_in(data_in),
        .data_out(data_out_s), .pc(pc_s), .count(count_s), .full(full_s),
        .overflow(overflow_s), .done(done_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sb.size() > 0)   chk("dout",   32'(data_out),   sb.pop_front());
        if (sb_s.size() > 0) chk("dout_s", 32'(data_out_s), sb_s.pop_front());
    endtask

    task automatic send(input logic [7:0] b, input int n);
        data_in = b;
        repeat (n) tick();
    endtask

    task automatic pulse_debug(input logic [7:0] exp);
        DEBUG = 1'b1; sb.push_back(32'(exp)); tick();
        DEBUG = 1'b0; sb.push_back(32'(exp)); tick();
    endtask

    initial begin
        logic [7:0] prog [4];
        prog[0] = 8'h4A; prog[1] = 8'h4B; prog[2] = 8'h4C; prog[3] = 8'h4D;

        // reset
        rst = 1'b1; MODE = 2'd1; DEBUG = 1'b0; data_in = 8'h00;
        tick();
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // load with 4-cycle held bytes
        send(8'h00, 4);
        for (int i = 0; i < 4; i++) begin
            send(prog[i], 4);
            send(8'h24, 4);
        end
        chk("load_count", 32'(count), 4);
        chk("load_dout_held", 32'(data_out), 0);
        chk("load_done", 32'(done), 0);
        chk("load_full", 32'(full), 0);
        chk("load_full_s", 32'(full_s), 1);

        // run
        MODE = 2'd0;
        for (int i = 0; i < 4; i++) sb.push_back(32'(prog[i]));
        for (int i = 0; i < 20; i++) sb.push_back(32'h4D);
        repeat (24) tick();
        chk("run_pc", 32'(pc), 3);
        chk("run_done", 32'(done), 1);

        // step
        MODE = 2'd2;
        sb.push_back(32'h4A); tick();
        chk("step_pc0", 32'(pc), 0);
        for (int i = 1; i < 4; i++) pulse_debug(prog[i]);
        for (int i = 0; i < 4; i++) pulse_debug(8'h4D);
        chk("step_pc_sat", 32'(pc), 3);
        chk("step_done", 32'(done), 1);

        // level held high gives a single step
        MODE = 2'd3; sb.push_back(32'h4D); tick();
        MODE = 2'd2; sb.push_back(32'h4A); tick();
        DEBUG = 1'b1;
        for (int i = 0; i < 10; i++) sb.push_back(32'h4B);
        repeat (10) tick();
        DEBUG = 1'b0; sb.push_back(32'h4B); tick();
        chk("level_pc", 32'(pc), 1);

        // HOLD freezes outputs
        MODE = 2'd3;
        for (int i = 0; i < 6; i++) sb.push_back(32'h4B);
        repeat (2) tick();
        pulse_debug(8'h4B);
        repeat (2) tick();
        chk("hold_pc", 32'(pc), 1);

        // mode entry beats a simultaneous DEBUG edge
        MODE = 2'd1; tick();
        chk("rewrite_count", 32'(count), 0);
        send(8'h11, 2); send(8'h24, 2); send(8'h22, 2); send(8'h24, 2);
        send(8'h33, 2); send(8'h24, 2); send(8'h44, 2); send(8'h24, 2);
        chk("rewrite_count4", 32'(count), 4);
        MODE = 2'd2; DEBUG = 1'b1;
        sb.push_back(32'h11); tick();
        chk("entry_dbg_pc", 32'(pc), 0);
        sb.push_back(32'h11); tick();
        chk("entry_dbg_pc2", 32'(pc), 0);
        DEBUG = 1'b0;

        // reset mid-READ at pc=2
        MODE = 2'd0;
        sb.push_back(32'h11); sb.push_back(32'h22); sb.push_back(32'h33);
        repeat (3) tick();
        chk("mid_pc", 32'(pc), 2);
        rst = 1'b1; tick();
        chk("mrst_pc", 32'(pc), 0);
        chk("mrst_dout", 32'(data_out), 0);
        chk("mrst_count", 32'(count), 0);
        rst = 1'b0;

        // READ with empty program
        for (int i = 0; i < 4; i++) sb.push_back(32'h0);
        repeat (4) tick();
        chk("empty_pc", 32'(pc), 0);
        chk("empty_done", 32'(done), 1);

        // overflow on the DEPTH=4 instance
        MODE = 2'd1; tick();
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h51 + i), 2);
            send(8'h24, 2);
        end
        chk("ovf_count_s", 32'(count_s), 4);
        chk("ovf_full_s", 32'(full_s), 1);
        chk("ovf_flag_s", 32'(overflow_s), 1);
        chk("ovf_count", 32'(count), 6);
        chk("ovf_flag", 32'(overflow), 0);
        MODE = 2'd0;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(32'(8'h51 + i));
            sb_s.push_back(32'(i < 4 ? 8'h51 + i : 8'h54));
        end
        repeat (6) tick();
        MODE = 2'd3; tick();
        MODE = 2'd1; tick();
        chk("reent_count_s", 32'(count_s), 0);
        chk("reent_ovf_s", 32'(overflow_s), 0);
        chk("reent_full_s", 32'(full_s), 0);

        chk("sb_drained", 32'(sb.size() + sb_s.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
